// File: rtl/serial_port_if.sv
// CPU device-I/O bus seen by the UART peripheral, plus FSM state taps for debug.
// The CPU drives master; the peripheral implements slave.
interface serial_port_if;
    logic [7:0]  addr;
    logic [15:0] bus_in;
    logic        DI;
    logic        DO;
    logic [15:0] bus_out;
    logic        bus_oe;
    logic [1:0]  tx_fsm;
    logic [1:0]  rx_fsm;

    // DI writes and DO reads are single-cycle strobes with no stall: a write is
    // taken on the rising edge where DI=1, and a read returns bus_out in the
    // same cycle with any pop committed on the edge that ends it. DI wins over DO.
    modport master (
        output addr, bus_in, DI, DO,
        input  bus_out, bus_oe, tx_fsm, rx_fsm
    );

    modport slave (
        input  addr, bus_in, DI, DO,
        output bus_out, bus_oe, tx_fsm, rx_fsm
    );
endinterface

// File: rtl/serial_port.sv
// Memory-mapped 8N1 UART: DATA register at BASE_ADDR, STATUS at BASE_ADDR+1,
// with a TX FIFO feeding the transmitter and an RX FIFO fed by the receiver.
module serial_port #(
    parameter int         CLKS_PER_BIT = 16,
    parameter logic [7:0] BASE_ADDR    = 8'h88,
    parameter int         FIFO_LOG2    = 2
) (
    input  logic         clk,
    input  logic         reset,
    serial_port_if.slave bus,
    input  logic         rx,
    output logic         tx
);
    localparam int                DEPTH       = 1 << FIFO_LOG2;
    localparam int                TW          = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0]     BIT_LAST    = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0]     HALF_LAST   = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0]     TIMER_ONE   = TW'(1);
    localparam logic [FIFO_LOG2:0] PTR_ONE    = (FIFO_LOG2 + 1)'(1);
    localparam logic [7:0]        STATUS_ADDR = BASE_ADDR + 8'd1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic wr_data, rd_data, rd_status;
    assign wr_data   = bus.DI && (bus.addr == BASE_ADDR);
    assign rd_data   = bus.DO && !bus.DI && (bus.addr == BASE_ADDR);
    assign rd_status = bus.DO && !bus.DI && (bus.addr == STATUS_ADDR);
    assign bus.bus_oe = rd_data || rd_status;

    logic unused_bus_bits;
    assign unused_bus_bits = ^bus.bus_in[15:8];

    // TX FIFO
    logic [7:0]         tx_mem [DEPTH];
    logic [FIFO_LOG2:0] tx_wptr, tx_rptr;
    logic               tx_empty, tx_full, tx_push, tx_pop;
    logic [1:0]         tx_state;
    logic [TW-1:0]      tx_timer;
    logic [2:0]         tx_bit;
    logic [7:0]         tx_shift;

    assign tx_empty = (tx_wptr == tx_rptr);
    assign tx_full  = (tx_wptr[FIFO_LOG2] != tx_rptr[FIFO_LOG2]) &&
                      (tx_wptr[FIFO_LOG2-1:0] == tx_rptr[FIFO_LOG2-1:0]);
    assign tx_push  = wr_data && !tx_full;
    assign tx_pop   = !tx_empty &&
                      ((tx_state == S_IDLE) || (tx_state == S_STOP && tx_timer == BIT_LAST));

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr[FIFO_LOG2-1:0]] <= bus.bus_in[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + PTR_ONE;
            if (tx_pop)  tx_rptr <= tx_rptr + PTR_ONE;
        end
    end

    // tx follows the state one clock late, so every bit keeps its full width.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= S_IDLE;
            tx_timer <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx       <= 1'b1;
        end else begin
            tx <= (tx_state == S_START) ? 1'b0 :
                  (tx_state == S_DATA)  ? tx_shift[0] : 1'b1;
            case (tx_state)
                S_IDLE: begin
                    if (tx_pop) begin
                        tx_state <= S_START;
                        tx_shift <= tx_mem[tx_rptr[FIFO_LOG2-1:0]];
                        tx_timer <= '0;
                    end
                end
                S_START: begin
                    if (tx_timer == BIT_LAST) begin
                        tx_timer <= '0;
                        tx_bit   <= '0;
                        tx_state <= S_DATA;
                    end else tx_timer <= tx_timer + TIMER_ONE;
                end
                S_DATA: begin
                    if (tx_timer == BIT_LAST) begin
                        tx_timer <= '0;
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        if (tx_bit == 3'd7) tx_state <= S_STOP;
                        else tx_bit <= tx_bit + 3'd1;
                    end else tx_timer <= tx_timer + TIMER_ONE;
                end
                default: begin
                    if (tx_timer == BIT_LAST) begin
                        tx_timer <= '0;
                        if (tx_pop) begin
                            tx_state <= S_START;
                            tx_shift <= tx_mem[tx_rptr[FIFO_LOG2-1:0]];
                        end else tx_state <= S_IDLE;
                    end else tx_timer <= tx_timer + TIMER_ONE;
                end
            endcase
        end
    end

    // RX synchroniser, receiver and FIFO
    logic               rx_s1, rx_s2, rx_prev;
    logic [1:0]         rx_state;
    logic [TW-1:0]      rx_timer;
    logic [2:0]         rx_bit;
    logic [7:0]         rx_shift;
    logic [7:0]         rx_mem [DEPTH];
    logic [FIFO_LOG2:0] rx_wptr, rx_rptr;
    logic               rx_empty, rx_full, rx_pop, rx_push, rx_wr, stop_sample;
    logic               frame_err, overrun;

    assign rx_empty    = (rx_wptr == rx_rptr);
    assign rx_full     = (rx_wptr[FIFO_LOG2] != rx_rptr[FIFO_LOG2]) &&
                         (rx_wptr[FIFO_LOG2-1:0] == rx_rptr[FIFO_LOG2-1:0]);
    assign stop_sample = (rx_state == S_STOP) && (rx_timer == BIT_LAST);
    assign rx_push     = stop_sample && rx_s2;
    assign rx_pop      = rd_data && !rx_empty;
    assign rx_wr       = rx_push && (!rx_full || rx_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state <= S_IDLE;
            rx_timer <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            case (rx_state)
                S_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_state <= S_START;
                        rx_timer <= '0;
                    end
                end
                S_START: begin
                    // A start bit that is gone by mid-bit was a glitch.
                    if (rx_timer == HALF_LAST) begin
                        rx_timer <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s2 ? S_IDLE : S_DATA;
                    end else rx_timer <= rx_timer + TIMER_ONE;
                end
                S_DATA: begin
                    if (rx_timer == BIT_LAST) begin
                        rx_timer <= '0;
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        if (rx_bit == 3'd7) rx_state <= S_STOP;
                        else rx_bit <= rx_bit + 3'd1;
                    end else rx_timer <= rx_timer + TIMER_ONE;
                end
                default: begin
                    if (rx_timer == BIT_LAST) begin
                        rx_timer <= '0;
                        rx_state <= S_IDLE;
                    end else rx_timer <= rx_timer + TIMER_ONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rx_wr) rx_mem[rx_wptr[FIFO_LOG2-1:0]] <= rx_shift;
    end

    // A flag raised on the same edge as a STATUS read stays set.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wptr   <= '0;
            rx_rptr   <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (rx_wr)  rx_wptr <= rx_wptr + PTR_ONE;
            if (rx_pop) rx_rptr <= rx_rptr + PTR_ONE;
            frame_err <= (stop_sample && !rx_s2) || (frame_err && !rd_status);
            overrun   <= (rx_push && rx_full && !rx_pop) || (overrun && !rd_status);
        end
    end

    always_comb begin
        bus.bus_out = 16'h0000;
        if (bus.addr == BASE_ADDR) begin
            if (!rx_empty) bus.bus_out = {8'h00, rx_mem[rx_rptr[FIFO_LOG2-1:0]]};
        end else if (bus.addr == STATUS_ADDR) begin
            bus.bus_out = {11'b0, frame_err, overrun,
                           (tx_state != S_IDLE) || !tx_empty, tx_full, !rx_empty};
        end
    end

    assign bus.tx_fsm = tx_state;
    assign bus.rx_fsm = rx_state;
endmodule

// File: tb/tb_serial_port.sv
// Scoreboard bench for serial_port: randomized CPU writes/reads and rx frames
// against a queue-based model of the FIFOs, flags and serial framing.
module tb_serial_port;
    localparam int         CPB   = 16;
    localparam int         DEPTH = 4;
    localparam logic [7:0] BASE  = 8'h88;
    localparam logic [7:0] STAT  = 8'h89;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx = 1'b1;
    logic tx;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    serial_port_if bus();

    serial_port #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE), .FIFO_LOG2(2)) dut (
        .clk(clk), .reset(reset), .bus(bus), .rx(rx), .tx(tx)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // model state and scoreboard queues
    logic [16:0] exp_q[$];
    logic [7:0]  exp_tx_q[$];
    logic [7:0]  rx_model_q[$];
    int          start_cyc_q[$];
    int          tx_occ = 0, tx_accepted = 0, tx_done = 0, reset_gen = 0;
    bit          model_ferr = 0, model_ovr = 0;
    logic [16:0] rd_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // read monitor: every DO cycle pops one expectation
    always @(negedge clk) begin
        if (bus.DO) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_unexpected actual=%h required=none", bus.bus_out);
            end else begin
                rd_exp = exp_q.pop_front();
                if (rd_exp[16]) check("rd_data", {15'b0, bus.bus_oe, bus.bus_out}, {15'b0, rd_exp});
                else            check("rd_oe", {31'b0, bus.bus_oe}, 32'd0);
            end
        end else begin
            check("oe_idle", {31'b0, bus.bus_oe}, 32'd0);
        end
    end

    // tx monitor: decodes frames at mid-bit and compares with accepted bytes
    initial begin : tx_monitor
        int         gen;
        logic [7:0] b;
        logic       stop_b;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                gen = reset_gen;
                start_cyc_q.push_back(cyc);
                if (tx_occ > 0) tx_occ--;
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                stop_b = tx;
                if (gen == reset_gen) begin
                    tx_done++;
                    if (exp_tx_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL tx_unexpected actual=%h required=none", b);
                    end else begin
                        check("tx_frame", {23'b0, stop_b, b}, {23'b0, 1'b1, exp_tx_q.pop_front()});
                    end
                end
            end
        end
    end

    // driver tasks
    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d, input bit with_do);
        @(posedge clk); #1;
        bus.addr   = a;
        bus.bus_in = {8'($urandom_range(0, 255)), d};
        bus.DI     = 1'b1;
        bus.DO     = with_do;
        if (with_do) exp_q.push_back(17'h0);
        if (a == BASE && tx_occ < DEPTH) begin
            tx_occ++;
            tx_accepted++;
            exp_tx_q.push_back(d);
        end
        @(posedge clk); #1;
        bus.DI = 1'b0;
        bus.DO = 1'b0;
    endtask

    task automatic cpu_read(input logic [7:0] a);
        @(posedge clk); #1;
        bus.addr = a;
        bus.DO   = 1'b1;
        if (a == BASE) begin
            if (rx_model_q.size() == 0) exp_q.push_back({1'b1, 16'h0000});
            else exp_q.push_back({1'b1, 8'h00, rx_model_q.pop_front()});
        end else if (a == STAT) begin
            exp_q.push_back({1'b1, 11'b0, model_ferr, model_ovr, tx_accepted != tx_done,
                             tx_occ == DEPTH, rx_model_q.size() != 0});
            model_ferr = 0;
            model_ovr  = 0;
        end else begin
            exp_q.push_back(17'h0);
        end
        @(posedge clk); #1;
        bus.DO = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] d, input bit stop_bit);
        @(posedge clk); #1;
        rx = 1'b0;
        for (int i = 0; i < 9; i++) begin
            repeat (CPB) @(posedge clk); #1;
            rx = (i < 8) ? d[i] : stop_bit;
        end
        repeat (CPB) @(posedge clk); #1;
        rx = 1'b1;
        if (!stop_bit) model_ferr = 1;
        else if (rx_model_q.size() < DEPTH) rx_model_q.push_back(d);
        else model_ovr = 1;
    endtask

    task automatic wait_tx_drain();
        int n = 0;
        while (exp_tx_q.size() != 0 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        check("tx_drain", exp_tx_q.size(), 0);
        repeat (2 * CPB) @(posedge clk);
    endtask

    initial begin : watchdog
        #600000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int idx;
        bus.addr = 8'h00; bus.bus_in = 16'h0; bus.DI = 1'b0; bus.DO = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("tx_in_reset", {31'b0, tx}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        cpu_read(STAT);
        cpu_read(BASE);

        // single byte, latency and bit order
        cpu_write(BASE, 8'hA5, 0);
        @(posedge clk); @(negedge clk);
        check("tx_lat_edge1", {31'b0, tx}, 32'd1);
        @(posedge clk); @(negedge clk);
        check("tx_lat_edge2", {31'b0, tx}, 32'd0);
        wait_tx_drain();
        cpu_read(STAT);

        // overfill TX FIFO while transmitting; accepted bytes go back to back
        idx = start_cyc_q.size();
        cpu_write(BASE, 8'($urandom_range(0, 255)), 0);
        repeat (3 * CPB) @(posedge clk);
        for (int i = 0; i < 5; i++) cpu_write(BASE, 8'($urandom_range(0, 255)), 0);
        cpu_read(STAT);
        wait_tx_drain();
        check("tx_frame_count", start_cyc_q.size() - idx, 5);
        if (start_cyc_q.size() - idx == 5)
            for (int i = 1; i < 5; i++)
                check("tx_gap", start_cyc_q[idx+i] - start_cyc_q[idx+i-1], 10 * CPB);
        cpu_read(STAT);

        // DI and DO together, and unmapped addresses
        cpu_write(BASE, 8'($urandom_range(0, 255)), 1);
        cpu_write(8'h90, 8'($urandom_range(0, 255)), 0);
        cpu_read(8'h87);
        wait_tx_drain();

        // receive and read back
        for (int k = 0; k < 3; k++) begin
            send_rx((k == 0) ? 8'h3C : 8'($urandom_range(0, 255)), 1);
            cpu_read(STAT);
            cpu_read(BASE);
            cpu_read(STAT);
            cpu_read(BASE);
        end

        // overrun
        for (int k = 0; k < 5; k++) send_rx(8'($urandom_range(0, 255)), 1);
        cpu_read(STAT);
        for (int k = 0; k < 4; k++) cpu_read(BASE);
        cpu_read(STAT);

        // glitch reject, then framing error
        @(posedge clk); #1;
        rx = 1'b0;
        repeat (4) @(posedge clk); #1;
        rx = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        cpu_read(STAT);
        send_rx(8'($urandom_range(0, 255)), 0);
        repeat (4) @(posedge clk);
        cpu_read(STAT);
        cpu_read(STAT);
        cpu_read(BASE);

        // reset mid TX data bit and mid RX frame
        cpu_write(BASE, 8'($urandom_range(0, 255)), 0);
        @(posedge clk); #1;
        rx = 1'b0;
        repeat (3 * CPB) @(posedge clk); #1;
        reset = 1'b1;
        exp_tx_q.delete();
        rx_model_q.delete();
        tx_occ = 0; tx_accepted = 0; tx_done = 0;
        model_ferr = 0; model_ovr = 0;
        reset_gen++;
        @(negedge clk);
        check("tx_after_reset", {31'b0, tx}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        rx = 1'b1;
        repeat (12 * CPB) @(posedge clk);
        cpu_read(STAT);
        cpu_read(BASE);
        @(negedge clk);
        check("tx_idle_end", {31'b0, tx}, 32'd1);

        check("rd_queue_empty", exp_q.size(), 0);
        check("tx_queue_empty", exp_tx_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
